// File: rtl/vend_dispense_scheduler_if.sv
// vend_dispense_scheduler_if: pick/credit inputs plus dispense and coin handshakes of the scheduler
interface vend_dispense_scheduler_if;
  logic [3:0] bt_pick;
  logic [3:0] kb_pick;
  logic       cancel;
  logic [6:0] credit;
  logic       disp_ack;
  logic       coin_ack;
  logic [3:0] drink_sel;
  logic       disp_req;
  logic       coin_req;
  logic [1:0] coin_type;
  logic       busy;
  logic       done;
  logic       reject;
  logic       fault;
  logic [6:0] remaining;
  modport master (
    output bt_pick, kb_pick, cancel, credit, disp_ack, coin_ack,
    input  drink_sel, disp_req, coin_req, coin_type, busy, done, reject, fault, remaining
  );
  modport slave (
    input  bt_pick, kb_pick, cancel, credit, disp_ack, coin_ack,
    output drink_sel, disp_req, coin_req, coin_type, busy, done, reject, fault, remaining
  );
endinterface

// File: rtl/vend_dispense_scheduler.sv
// vend_dispense_scheduler: arbitrates picks, checks credit, dispenses and pays greedy 50/10/5 change.
// Define VEND_SCHED_TIMEOUT_EN to abort a handshake with a fault pulse after TIMEOUT cycles without ack.
module vend_dispense_scheduler #(
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1000
) (
  input logic clk,
  input logic rst,
  vend_dispense_scheduler_if.slave bus
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, EVAL, DISPENSE, CHANGE, GAP} state_t;
  state_t     state, state_nx;
  logic [3:0] sel_q, sel_nx;
  logic       ptr_q, ptr_nx;
  logic [6:0] rem_q, rem_nx;
  logic [GW-1:0] gap_q, gap_nx;
  logic       done_q, done_nx, reject_q, reject_nx;
  logic       bt_any, kb_any, use_kb, gap_last;
  logic [3:0] pick, grant;
  logic [6:0] price, coin_val;
  logic [1:0] coin_t;
  assign bt_any   = |bus.bt_pick;
  assign kb_any   = |bus.kb_pick;
  assign use_kb   = kb_any & (~bt_any | ptr_q);
  assign pick     = use_kb ? bus.kb_pick : bus.bt_pick;
  assign grant    = pick & (~pick + 4'd1);
  assign price    = sel_q[0] ? 7'd55 : sel_q[1] ? 7'd20 : sel_q[2] ? 7'd25 : 7'd30;
  assign coin_t   = rem_q >= 7'd50 ? 2'd2 : rem_q >= 7'd10 ? 2'd1 : 2'd0;
  assign coin_val = coin_t == 2'd2 ? 7'd50 : coin_t == 2'd1 ? 7'd10 : 7'd5;
  assign gap_last = gap_q == GW'(GAP_CYCLES - 1);
`ifdef VEND_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          fault_q, fault_nx, timeout;
  assign timeout = tmo_q == TW'(TIMEOUT - 1);
  // Counts consecutive cycles a request has been waiting; clears whenever the state moves on.
  always_ff @(posedge clk or negedge rst)
    if (!rst) tmo_q <= '0;
    else tmo_q <= ((state == DISPENSE || state == CHANGE) && state_nx == state) ? tmo_q + 1'b1 : '0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      sel_q    <= '0;
      ptr_q    <= 1'b0;
      rem_q    <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
`ifdef VEND_SCHED_TIMEOUT_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      sel_q    <= sel_nx;
      ptr_q    <= ptr_nx;
      rem_q    <= rem_nx;
      gap_q    <= gap_nx;
      done_q   <= done_nx;
      reject_q <= reject_nx;
`ifdef VEND_SCHED_TIMEOUT_EN
      fault_q  <= fault_nx;
`endif
    end
  always_comb begin
    state_nx  = state;
    sel_nx    = sel_q;
    ptr_nx    = ptr_q;
    rem_nx    = rem_q;
    gap_nx    = gap_q;
    done_nx   = 1'b0;
    reject_nx = 1'b0;
`ifdef VEND_SCHED_TIMEOUT_EN
    fault_nx  = 1'b0;
`endif
    case (state)
      IDLE:
        if (bus.cancel) begin
          rem_nx   = bus.credit;
          state_nx = bus.credit != 7'd0 ? CHANGE : IDLE;
          done_nx  = bus.credit == 7'd0;
        end else if (bt_any | kb_any) begin
          sel_nx   = grant;
          rem_nx   = '0;
          ptr_nx   = (bt_any & kb_any) ? ~ptr_q : ptr_q;
          state_nx = EVAL;
        end
      EVAL:
        if (bus.credit < price) begin
          reject_nx = 1'b1;
          state_nx  = IDLE;
        end else begin
          rem_nx   = bus.credit - price;
          state_nx = DISPENSE;
        end
      DISPENSE:
        if (bus.disp_ack) begin
          state_nx = rem_q != 7'd0 ? CHANGE : IDLE;
          done_nx  = rem_q == 7'd0;
        end
`ifdef VEND_SCHED_TIMEOUT_EN
        else if (timeout) begin
          fault_nx = 1'b1;
          state_nx = IDLE;
        end
`endif
      CHANGE:
        if (bus.coin_ack) begin
          rem_nx   = rem_q - coin_val;
          gap_nx   = '0;
          state_nx = GAP;
        end
`ifdef VEND_SCHED_TIMEOUT_EN
        else if (timeout) begin
          fault_nx = 1'b1;
          state_nx = IDLE;
        end
`endif
      GAP:
        if (!gap_last) gap_nx = gap_q + 1'b1;
        else if (rem_q >= 7'd5) state_nx = CHANGE;
        else begin
          rem_nx   = '0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.busy      = state != IDLE;
    bus.disp_req  = state == DISPENSE;
    bus.coin_req  = state == CHANGE;
    bus.drink_sel = state == DISPENSE ? sel_q : 4'd0;
    bus.coin_type = state == CHANGE ? coin_t : 2'd0;
    bus.remaining = (state == EVAL || state == DISPENSE) ? 7'd0 : rem_q;
    bus.done      = done_q;
    bus.reject    = reject_q;
`ifdef VEND_SCHED_TIMEOUT_EN
    bus.fault     = fault_q;
`else
    bus.fault     = 1'b0;
`endif
  end
endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// tb_vend_dispense_scheduler: table of transactions with an event scoreboard, plus reject-timing, busy-drop and reset sequences.
module tb_vend_dispense_scheduler;
  localparam int GAP = 4;
  typedef struct {
    logic [3:0] bt;
    logic [3:0] kb;
    logic       cn;
    logic [6:0] cr;
    logic       rej;
    logic [3:0] sel;
    int         nc;
    logic [7:0] coins;
  } vec_t;
  typedef struct { int k; int v; } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0, n_err = 0, disp_delay = 3, dcnt = 0;
  ev_t  q[$];
  vec_t vt[12];
  vend_dispense_scheduler_if b();
  vend_dispense_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT(1000)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  initial forever #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic push(input int k, input int v);
    ev_t e;
    e.k = k;
    e.v = v;
    q.push_back(e);
  endtask
  task automatic ev(input int k, input int v);
    ev_t e;
    if (q.size() == 0) chk("unexpected_event", k * 100 + v, -1);
    else begin
      e = q.pop_front();
      chk("event", k * 100 + v, e.k * 100 + e.v);
    end
  endtask
  task automatic wait_empty(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !b.busy) break;
    end
    if (k == budget) chk("txn_timeout", q.size(), 0);
  endtask
  initial begin
    b.disp_ack = 1'b0;
    b.coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (b.disp_req && !b.disp_ack) begin
        if (dcnt == disp_delay) b.disp_ack = 1'b1;
        else dcnt++;
      end else begin
        b.disp_ack = 1'b0;
        dcnt = 0;
      end
      b.coin_ack = b.coin_req && !b.coin_ack;
    end
  end
  initial begin
    logic pd, pc, sc;
    int hi, lo;
    pd = 0; pc = 0; sc = 0; hi = 0; lo = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pd = 0; pc = 0; sc = 0; hi = 0; lo = 0;
        continue;
      end
      if (b.disp_req) hi++;
      if (b.disp_req && !pd) ev(1, int'(b.drink_sel));
      if (!b.disp_req && pd) begin
        chk("disp_hold", hi, disp_delay + 1);
        hi = 0;
      end
      if (b.coin_req && !pc) begin
        if (sc) chk("gap_len", lo, GAP);
        ev(2, int'(b.coin_type));
        sc = 1;
        lo = 0;
      end
      if (!b.coin_req) lo++;
      if (b.done) begin
        ev(3, 0);
        chk("done_remaining", int'(b.remaining), 0);
        sc = 0;
      end
      if (b.reject) ev(4, 0);
      if (b.fault) chk("fault", 1, 0);
      pd = b.disp_req;
      pc = b.coin_req;
    end
  end
  initial begin
    vt[0]  = '{4'b0001, 4'b0000, 1'b0, 7'd80, 1'b0, 4'b0001, 3, 8'h05};
    vt[1]  = '{4'b0000, 4'b0100, 1'b0, 7'd20, 1'b1, 4'b0000, 0, 8'h00};
    vt[2]  = '{4'b0010, 4'b1000, 1'b0, 7'd80, 1'b0, 4'b0010, 2, 8'h06};
    vt[3]  = '{4'b0010, 4'b1000, 1'b0, 7'd80, 1'b0, 4'b1000, 1, 8'h02};
    vt[4]  = '{4'b0000, 4'b0000, 1'b1, 7'd65, 1'b0, 4'b0000, 3, 8'h06};
    vt[5]  = '{4'b0000, 4'b0000, 1'b1, 7'd0,  1'b0, 4'b0000, 0, 8'h00};
    vt[6]  = '{4'b0110, 4'b0000, 1'b0, 7'd20, 1'b0, 4'b0010, 0, 8'h00};
    vt[7]  = '{4'b0000, 4'b1000, 1'b0, 7'd25, 1'b1, 4'b0000, 0, 8'h00};
    vt[8]  = '{4'b0001, 4'b0010, 1'b0, 7'd55, 1'b0, 4'b0001, 0, 8'h00};
    vt[9]  = '{4'b0001, 4'b0100, 1'b0, 7'd80, 1'b0, 4'b0100, 2, 8'h02};
    vt[10] = '{4'b0001, 4'b0000, 1'b1, 7'd15, 1'b0, 4'b0000, 2, 8'h01};
    vt[11] = '{4'b1000, 4'b0000, 1'b0, 7'd80, 1'b0, 4'b1000, 1, 8'h02};
    b.bt_pick = '0;
    b.kb_pick = '0;
    b.cancel  = 1'b0;
    b.credit  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(b.busy), 0);
    chk("rst_disp_req", int'(b.disp_req), 0);
    chk("rst_coin_req", int'(b.coin_req), 0);
    chk("rst_drink_sel", int'(b.drink_sel), 0);
    chk("rst_remaining", int'(b.remaining), 0);
    chk("rst_pulses", int'({b.done, b.reject, b.fault}), 0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      disp_delay = (i == 0) ? 3 : i % 4;
      if (vt[i].rej) push(4, 0);
      else begin
        if (!vt[i].cn) push(1, int'(vt[i].sel));
        for (int c = 0; c < vt[i].nc; c++) push(2, int'(vt[i].coins[2*c +: 2]));
        push(3, 0);
      end
      b.credit  = vt[i].cr;
      b.bt_pick = vt[i].bt;
      b.kb_pick = vt[i].kb;
      b.cancel  = vt[i].cn;
      @(negedge clk);
      b.bt_pick = '0;
      b.kb_pick = '0;
      b.cancel  = 1'b0;
      wait_empty(300);
    end
    // reject arrives two cycles after the pick
    @(negedge clk);
    push(4, 0);
    b.credit  = 7'd20;
    b.kb_pick = 4'b0100;
    @(negedge clk);
    b.kb_pick = '0;
    chk("eval_busy", int'(b.busy), 1);
    chk("eval_reject", int'(b.reject), 0);
    @(negedge clk);
    chk("reject_pulse", int'(b.reject), 1);
    chk("reject_no_disp", int'(b.disp_req), 0);
    wait_empty(50);
    // pick while paying change is dropped
    @(negedge clk);
    push(2, 2); push(2, 1); push(2, 0); push(3, 0);
    b.credit = 7'd65;
    b.cancel = 1'b1;
    @(negedge clk);
    b.cancel = 1'b0;
    for (int k = 0; k < 50 && !b.coin_req; k++) @(negedge clk);
    chk("change_reached", int'(b.coin_req), 1);
    b.bt_pick = 4'b0001;
    @(negedge clk);
    b.bt_pick = '0;
    wait_empty(300);
    repeat (3) @(negedge clk);
    chk("dropped_pick_idle", int'(b.busy), 0);
    // asynchronous reset in the middle of change
    push(2, 2);
    b.credit = 7'd80;
    b.cancel = 1'b1;
    @(negedge clk);
    b.cancel = 1'b0;
    for (int k = 0; k < 50 && !b.coin_req; k++) @(negedge clk);
    chk("reset_change_reached", int'(b.coin_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", int'(b.busy), 0);
    chk("async_coin_req", int'(b.coin_req), 0);
    chk("async_remaining", int'(b.remaining), 0);
    chk("async_coin_type", int'(b.coin_type), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_busy", int'(b.busy), 0);
    chk("post_reset_remaining", int'(b.remaining), 0);
    chk("post_reset_pending", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
